cellnet_relay: RTL and testbench

CELLNET_RELAY -- requirements
Module: cellnet_relay

---
 rtl/cellnet_relay.sv | 169 ++++++++++++++++
 tb/tb_cellnet_relay.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cellnet_relay.sv
`default_nettype none
// ============================================================================
//  Module   : cellnet_relay
//  Purpose  : Two-phase handshake relay between two asynchronous peers with a
//             DEPTH-entry FIFO buffering {address, data} words in the i_clk domain.
//  Revision : 1.0  initial release
// ============================================================================

`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 8
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif

module cellnet_relay #(
    parameter int ADDR_W = `ADDRESS_SIZE,
    parameter int DATA_W = `DATA_SIZE,
    parameter int DEPTH  = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_req,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic [DATA_W-1:0]        i_dat,
    output logic                     o_ack,
    output logic                     o_req,
    output logic [ADDR_W-1:0]        o_addr,
    output logic [DATA_W-1:0]        o_dat,
    input  logic                     i_ack,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_err
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = ADDR_W + DATA_W;

    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_ZERO = '0;
    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic              req_s1_q, req_s1_d, req_s_q, req_s_d;
    logic              ack_s1_q, ack_s1_d, ack_s_q, ack_s_d;
    logic              ack_prev_q, ack_prev_d;
    logic              ack_q, ack_d;
    logic              oreq_q, oreq_d;
    logic [ADDR_W-1:0] oaddr_q, oaddr_d;
    logic [DATA_W-1:0] odat_q, odat_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [0:0]        state_q, state_d;
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];

    logic              w_pending;
    logic              w_push;
    logic              w_pop;
    logic [WORD_W-1:0] w_head;

    always_comb begin
        req_s1_d   = i_req;
        req_s_d    = req_s1_q;
        ack_s1_d   = i_ack;
        ack_s_d    = ack_s1_q;
        ack_prev_d = ack_s_q;

        ack_d      = ack_q;
        oreq_d     = oreq_q;
        oaddr_d    = oaddr_q;
        odat_d     = odat_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        state_d    = state_q;
        mem_d      = mem_q;

        // Only synchronized handshake levels steer the datapath.
        w_pending  = (req_s_q != ack_q);
        w_push     = w_pending && (cnt_q < C_FULL);
        w_pop      = (state_q == ST_IDLE) && (cnt_q != C_ZERO);
        w_head     = mem_q[rd_ptr_q];

        if (w_push) begin
            mem_d[wr_ptr_q] = {i_addr, i_dat};
            wr_ptr_d        = wr_ptr_q + C_PTR_ONE;
            ack_d           = ~ack_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_pop) begin
                    {oaddr_d, odat_d} = w_head;
                    rd_ptr_d          = rd_ptr_q + C_PTR_ONE;
                    oreq_d            = ~oreq_q;
                    state_d           = ST_WAIT;
                end
                // An acknowledge with nothing outstanding is a peer protocol fault.
                if (ack_s_q != ack_prev_q) begin
                    err_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (ack_s_q == oreq_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            req_s1_q   <= 1'b0;
            req_s_q    <= 1'b0;
            ack_s1_q   <= 1'b0;
            ack_s_q    <= 1'b0;
            ack_prev_q <= 1'b0;
            ack_q      <= 1'b0;
            oreq_q     <= 1'b0;
            oaddr_q    <= '0;
            odat_q     <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= ST_IDLE;
            mem_q      <= '{default: '0};
        end else begin
            req_s1_q   <= req_s1_d;
            req_s_q    <= req_s_d;
            ack_s1_q   <= ack_s1_d;
            ack_s_q    <= ack_s_d;
            ack_prev_q <= ack_prev_d;
            ack_q      <= ack_d;
            oreq_q     <= oreq_d;
            oaddr_q    <= oaddr_d;
            odat_q     <= odat_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            mem_q      <= mem_d;
        end
    end

    assign o_ack   = ack_q;
    assign o_req   = oreq_q;
    assign o_addr  = oaddr_q;
    assign o_dat   = odat_q;
    assign o_count = cnt_q;
    assign o_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cellnet_relay.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cellnet_relay
//  Purpose  : Scoreboard bench for cellnet_relay with randomized upstream and
//             downstream handshake peers.
//  Revision : 1.0  initial release
// ============================================================================

module tb_cellnet_relay;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              i_rst_n;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_dat;
    logic              o_ack;
    logic              o_req;
    logic [ADDR_W-1:0] o_addr;
    logic [DATA_W-1:0] o_dat;
    logic              i_ack;
    logic [$clog2(DEPTH):0] o_count;
    logic              o_err;

    cellnet_relay #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (i_rst_n),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_dat   (i_dat),
        .o_ack   (o_ack),
        .o_req   (o_req),
        .o_addr  (o_addr),
        .o_dat   (o_dat),
        .i_ack   (i_ack),
        .o_count (o_count),
        .o_err   (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W+DATA_W-1:0] exp_q [$];
    bit auto_ack = 1'b0;
    int kick_req = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Downstream peer: acks outstanding words after a random delay, or
    // toggles i_ack on demand when kick_req is bumped.
    initial begin
        int kick_done = 0;
        int dly = -1;
        i_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!i_rst_n) begin
                i_ack     = 1'b0;
                kick_done = kick_req;
                dly       = -1;
            end else if (kick_done != kick_req) begin
                i_ack = ~i_ack;
                kick_done++;
            end else if (auto_ack && (o_req != i_ack)) begin
                if (dly < 0) dly = int'($urandom_range(0, 3));
                if (dly == 0) begin
                    i_ack = o_req;
                    dly   = -1;
                end else begin
                    dly--;
                end
            end
        end
    end

    // Monitor: every downstream launch must match the oldest accepted word, and
    // occupancy must equal upstream acks minus downstream launches.
    initial begin
        logic prev_req = 1'b0;
        logic prev_ack = 1'b0;
        int n_ack = 0;
        int n_req = 0;
        logic [ADDR_W+DATA_W-1:0] w;
        forever begin
            @(negedge clk);
            if (!i_rst_n) begin
                prev_req = 1'b0;
                prev_ack = 1'b0;
                n_ack    = 0;
                n_req    = 0;
            end else begin
                bit ev = 1'b0;
                if (o_ack !== prev_ack) begin
                    n_ack++;
                    prev_ack = o_ack;
                    ev = 1'b1;
                end
                if (o_req !== prev_req) begin
                    n_req++;
                    prev_req = o_req;
                    ev = 1'b1;
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_launch", {o_addr, o_dat}, -1);
                    end else begin
                        w = exp_q.pop_front();
                        chk("sb_word", {o_addr, o_dat}, w);
                    end
                end
                if (ev) chk("occupancy", o_count, n_ack - n_req);
            end
        end
    end

    task automatic send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(posedge clk); #2;
        i_addr = a;
        i_dat  = d;
        i_req  = ~i_req;
        exp_q.push_back({a, d});
    endtask

    task automatic wait_ack(input int bound);
        int n = 0;
        while (o_ack !== i_req && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ack_timeout", o_ack, i_req);
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (!(exp_q.size() == 0 && o_count == 0 && o_req == i_ack) && n < bound) begin
            @(negedge clk); #1;
            n++;
        end
        chk("drain_timeout", (n < bound) ? 1 : 0, 1);
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic ack_before;
        i_rst_n = 1'b0;
        i_req   = 1'b0;
        i_addr  = '0;
        i_dat   = '0;
        repeat (3) @(negedge clk);
        chk("rst_o_ack", o_ack, 0);
        chk("rst_o_req", o_req, 0);
        chk("rst_o_data", {o_addr, o_dat}, 0);
        chk("rst_o_count", o_count, 0);
        chk("rst_o_err", o_err, 0);
        #2 i_rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Single word latency
        auto_ack = 1'b1;
        send(8'd3, 8'h5A);
        @(posedge clk); #1;
        chk("lat_ack_e1", o_ack, 0);
        @(posedge clk); #1;
        chk("lat_ack_e2", o_ack, 0);
        @(posedge clk); #1;
        chk("lat_ack_e3", o_ack, 1);
        chk("lat_req_e3", o_req, 0);
        @(posedge clk); #1;
        chk("lat_req_e4", o_req, 1);
        chk("lat_addr_e4", o_addr, 3);
        chk("lat_dat_e4", o_dat, 8'h5A);
        chk("lat_count_e4", o_count, 0);
        wait_drain(300);

        // Fill with downstream stalled, then backpressure on the sixth word
        auto_ack = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            send(8'(k), 8'(k * 17));
            wait_ack(20);
        end
        repeat (3) @(posedge clk); #1;
        chk("fill_count", o_count, 4);
        ack_before = o_ack;
        send(8'd6, 8'h66);
        repeat (10) @(posedge clk); #1;
        chk("fill_backpressure", o_ack, ack_before);
        chk("fill_count_hold", o_count, 4);
        auto_ack = 1'b1;
        wait_ack(60);
        wait_drain(300);
        chk("fill_no_err", o_err, 0);

        // Simultaneous push and pop at occupancy 2
        auto_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send(8'hA0 + 8'(k), 8'hC0 + 8'(k));
            wait_ack(20);
        end
        repeat (3) @(posedge clk); #1;
        chk("sim_count_pre", o_count, 2);
        @(posedge clk); #2;
        kick_req++;
        send(8'hA3, 8'hC3);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("sim_count_hold", o_count, 2);
        end
        chk("sim_acked", o_ack, i_req);
        auto_ack = 1'b1;
        wait_drain(300);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            send(8'($urandom), 8'($urandom));
            wait_ack(100);
        end
        wait_drain(400);
        chk("rand_no_err", o_err, 0);

        // Spurious acknowledge while idle
        auto_ack = 1'b0;
        @(posedge clk); #2;
        kick_req++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("spur_err_e2", o_err, 0);
        @(posedge clk); #1;
        chk("spur_err_e3", o_err, 1);
        repeat (5) @(posedge clk); #1;
        chk("spur_err_sticky", o_err, 1);
        auto_ack = 1'b1;
        send(8'h3C, 8'hE7);
        wait_ack(30);
        wait_drain(300);
        chk("spur_err_after", o_err, 1);

        // Reset with words buffered
        auto_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send(8'h70 + 8'(k), 8'h90 + 8'(k));
            wait_ack(20);
        end
        repeat (3) @(posedge clk); #1;
        chk("mid_count_pre", o_count, 3);
        @(negedge clk); #2;
        i_rst_n = 1'b0;
        i_req   = 1'b0;
        #1;
        chk("mid_rst_ack", o_ack, 0);
        chk("mid_rst_req", o_req, 0);
        chk("mid_rst_data", {o_addr, o_dat}, 0);
        chk("mid_rst_count", o_count, 0);
        chk("mid_rst_err", o_err, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        #2 i_rst_n = 1'b1;
        auto_ack = 1'b1;
        repeat (8) @(posedge clk); #1;
        chk("post_rst_req", o_req, 0);
        chk("post_rst_ack", o_ack, 0);
        chk("post_rst_count", o_count, 0);
        send(8'h11, 8'h22);
        wait_ack(30);
        wait_drain(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
